// File: rtl/aux_multi_src_arbiter.sv
// ---------------------------------------------------------------------------
// aux_multi_src_arbiter
//
// Purpose:
//   N-source AUX request arbiter. Grants one requester at a time, latches
//   its transaction, launches it to the native/I2C encoder path and waits
//   for the reply decoder or the reply timeout timer. DEFER replies and
//   timeouts are retried up to MAX_RETRY times. Each source is told
//   whether its transaction succeeded (req_done) or failed (req_failed).
//
// Configuration macro:
//   AUX_ARB_FIXED_PRIO_EN - when defined, the lowest requesting index always
//                           wins and no round-robin pointer is built. Source 0
//                           can starve the others; this gives link training
//                           precedence. When undefined, grants rotate
//                           round-robin.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_vld           per-source request, held until req_rdy
//   req_cmd/addr/     per-source transaction fields, source i occupies
//   len/data            slice [W*i +: W]
//   req_rdy           one-cycle accept pulse to the granted source
//   req_done          one-cycle pulse when the owner's transaction is ACKed
//   req_failed        one-cycle pulse on NACK or when retries are exhausted
//   reply_ack(_vld)   reply decoder result: 00 ACK, 01 NACK, 10 DEFER,
//                     11 treated as NACK
//   timer_timeout     reply timeout pulse
//   arb_tr_vld        one-cycle launch pulse to the encoder
//   arb_cmd/address/  latched transaction of the current owner
//   len/data
//   arb_retrans       high together with arb_tr_vld on retry launches
//   arb_src           index of the current owner
//   arb_busy          high whenever the arbiter is not idle
// ---------------------------------------------------------------------------
module aux_multi_src_arbiter #(
  parameter int N_SRC     = 4,
  parameter int MAX_RETRY = 7,
  parameter int ADDR_W    = 20,
  parameter int SRC_W     = $clog2(N_SRC)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_SRC-1:0]        req_vld,
  input  logic [2*N_SRC-1:0]      req_cmd,
  input  logic [ADDR_W*N_SRC-1:0] req_addr,
  input  logic [8*N_SRC-1:0]      req_len,
  input  logic [8*N_SRC-1:0]      req_data,
  output logic [N_SRC-1:0]        req_rdy,
  output logic [N_SRC-1:0]        req_done,
  output logic [N_SRC-1:0]        req_failed,
  input  logic [1:0]              reply_ack,
  input  logic                    reply_ack_vld,
  input  logic                    timer_timeout,
  output logic                    arb_tr_vld,
  output logic [1:0]              arb_cmd,
  output logic [ADDR_W-1:0]       arb_address,
  output logic [7:0]              arb_len,
  output logic [7:0]              arb_data,
  output logic                    arb_retrans,
  output logic [SRC_W-1:0]        arb_src,
  output logic                    arb_busy
);

  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LAUNCH  = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_RESOLVE = 2'd3;

  logic [1:0]       state;
  logic [RW-1:0]    retry_cnt;
  logic [SRC_W-1:0] grant;
  logic             grant_vld;
  logic [N_SRC-1:0] grant_mask;
  logic [N_SRC-1:0] owner_mask;
  logic             is_ack;
  logic             is_defer;
  logic             is_nack;
  logic             retry_event;

  assign grant_mask = N_SRC'(1) << grant;
  assign owner_mask = N_SRC'(1) << arb_src;
  assign arb_busy   = (state != S_IDLE);

  // Reply classification. A valid reply always takes precedence over a
  // timeout arriving in the same cycle; code 11 is folded into NACK.
  assign is_ack      = reply_ack_vld && (reply_ack == 2'b00);
  assign is_defer    = reply_ack_vld && (reply_ack == 2'b10);
  assign is_nack     = reply_ack_vld && !is_ack && !is_defer;
  assign retry_event = is_defer || (!reply_ack_vld && timer_timeout);

`ifdef AUX_ARB_FIXED_PRIO_EN
  // Fixed priority: scan downward so the lowest requesting index is the
  // last one written and therefore wins.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req_vld[i]) begin
        grant     = SRC_W'(i);
        grant_vld = 1'b1;
      end
    end
  end
`else
  logic [SRC_W-1:0] rr_ptr;
  int               rr_idx;

  // Round-robin: scan N_SRC positions starting at rr_ptr, wrapping to 0,
  // and take the first requester found.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    rr_idx    = 0;
    for (int k = 0; k < N_SRC; k++) begin
      rr_idx = int'(rr_ptr) + k;
      if (rr_idx >= N_SRC) rr_idx = rr_idx - N_SRC;
      if (!grant_vld && req_vld[rr_idx]) begin
        grant     = SRC_W'(rr_idx);
        grant_vld = 1'b1;
      end
    end
  end

  // The pointer moves just past the source that was granted, so that
  // source has lowest priority in the next arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (state == S_IDLE && grant_vld) begin
      if (grant == SRC_W'(N_SRC - 1)) rr_ptr <= '0;
      else                            rr_ptr <= grant + SRC_W'(1);
    end
  end
`endif

  // Main transaction FSM. Pulse outputs default low every cycle and are
  // raised only in the cycle following the event that causes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      retry_cnt   <= '0;
      req_rdy     <= '0;
      req_done    <= '0;
      req_failed  <= '0;
      arb_tr_vld  <= 1'b0;
      arb_retrans <= 1'b0;
      arb_cmd     <= '0;
      arb_address <= '0;
      arb_len     <= '0;
      arb_data    <= '0;
      arb_src     <= '0;
    end else begin
      req_rdy     <= '0;
      req_done    <= '0;
      req_failed  <= '0;
      arb_tr_vld  <= 1'b0;
      arb_retrans <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_vld) begin
            req_rdy     <= grant_mask;
            arb_cmd     <= req_cmd[2*grant +: 2];
            arb_address <= req_addr[ADDR_W*grant +: ADDR_W];
            arb_len     <= req_len[8*grant +: 8];
            arb_data    <= req_data[8*grant +: 8];
            arb_src     <= grant;
            retry_cnt   <= '0;
            state       <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          arb_tr_vld  <= 1'b1;
          arb_retrans <= (retry_cnt != '0);
          state       <= S_WAIT;
        end
        S_WAIT: begin
          if (is_ack) begin
            req_done <= owner_mask;
            state    <= S_RESOLVE;
          end else if (is_nack) begin
            req_failed <= owner_mask;
            state      <= S_RESOLVE;
          end else if (retry_event) begin
            if (retry_cnt < RETRY_LIMIT) begin
              retry_cnt <= retry_cnt + RW'(1);
              state     <= S_LAUNCH;
            end else begin
              req_failed <= owner_mask;
              state      <= S_RESOLVE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aux_multi_src_arbiter.sv
// ---------------------------------------------------------------------------
// tb_aux_multi_src_arbiter
//
// Purpose: directed self-checking bench for aux_multi_src_arbiter with the
// default parameters (4 sources, MAX_RETRY 7, 20-bit address). Each source i
// carries distinctive fields so a latched transaction can be traced back to
// its owner. Define AUX_ARB_FIXED_PRIO_EN to check the fixed-priority build.
// ---------------------------------------------------------------------------
module tb_aux_multi_src_arbiter;

  localparam int N_SRC     = 4;
  localparam int MAX_RETRY = 7;
  localparam int ADDR_W    = 20;
  localparam int SRC_W     = 2;

  logic                    clk;
  logic                    rst_n;
  logic [N_SRC-1:0]        req_vld;
  logic [2*N_SRC-1:0]      req_cmd;
  logic [ADDR_W*N_SRC-1:0] req_addr;
  logic [8*N_SRC-1:0]      req_len;
  logic [8*N_SRC-1:0]      req_data;
  logic [N_SRC-1:0]        req_rdy;
  logic [N_SRC-1:0]        req_done;
  logic [N_SRC-1:0]        req_failed;
  logic [1:0]              reply_ack;
  logic                    reply_ack_vld;
  logic                    timer_timeout;
  logic                    arb_tr_vld;
  logic [1:0]              arb_cmd;
  logic [ADDR_W-1:0]       arb_address;
  logic [7:0]              arb_len;
  logic [7:0]              arb_data;
  logic                    arb_retrans;
  logic [SRC_W-1:0]        arb_src;
  logic                    arb_busy;

  int errors = 0;
  int checks = 0;

  aux_multi_src_arbiter #(
    .N_SRC(N_SRC), .MAX_RETRY(MAX_RETRY), .ADDR_W(ADDR_W), .SRC_W(SRC_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_cmd(req_cmd), .req_addr(req_addr),
    .req_len(req_len), .req_data(req_data),
    .req_rdy(req_rdy), .req_done(req_done), .req_failed(req_failed),
    .reply_ack(reply_ack), .reply_ack_vld(reply_ack_vld),
    .timer_timeout(timer_timeout),
    .arb_tr_vld(arb_tr_vld), .arb_cmd(arb_cmd), .arb_address(arb_address),
    .arb_len(arb_len), .arb_data(arb_data), .arb_retrans(arb_retrans),
    .arb_src(arb_src), .arb_busy(arb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-source field patterns, used both to drive the inputs and to check
  // the latched outputs.
  function automatic logic [ADDR_W-1:0] exp_addr(input int s);
    return ADDR_W'(32'h0A000 + s * 32'h111);
  endfunction
  function automatic logic [7:0] exp_data(input int s);
    return 8'(8'hC0 + s);
  endfunction

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until a launch pulse is seen, within a bounded number of cycles.
  task automatic run_until_launch(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (arb_tr_vld === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_reply(input logic [1:0] code, input logic tmo, input logic vld);
    reply_ack     = code;
    reply_ack_vld = vld;
    timer_timeout = tmo;
    step();
    reply_ack     = 2'b00;
    reply_ack_vld = 1'b0;
    timer_timeout = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    checks++;
    if ({arb_busy, arb_tr_vld, req_rdy, req_done, req_failed, arb_src, arb_address} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got busy=%b rdy=%b done=%b src=%0d addr=%h expected all 0",
               arb_busy, req_rdy, req_done, arb_src, arb_address);
    end
    rst_n = 1'b1;
    step();
    req_vld = 4'b0001;
    step();
    checks++;
    if (req_rdy !== 4'b0001 || arb_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_first_rdy got rdy=%b busy=%b expected 0001 1", req_rdy, arb_busy);
    end
    req_vld = 4'b0000;
    step();
    checks++;
    if (arb_tr_vld !== 1'b1 || arb_retrans !== 1'b0 || arb_address !== exp_addr(0)
        || arb_data !== exp_data(0) || arb_cmd !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_first_launch got tr=%b re=%b addr=%h data=%h expected 1 0 %h %h",
               arb_tr_vld, arb_retrans, arb_address, arb_data, exp_addr(0), exp_data(0));
    end
    send_reply(2'b00, 1'b0, 1'b1);
    checks++;
    if (req_done !== 4'b0001 || req_failed !== 4'b0000 || arb_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_done got done=%b failed=%b busy=%b expected 0001 0000 1",
               req_done, req_failed, arb_busy);
    end
    step();
    checks++;
    if (arb_busy !== 1'b0 || req_done !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_idle_after_resolve got busy=%b done=%b expected 0 0000", arb_busy, req_done);
    end
  endtask

  task automatic test_round_robin();
    int  exp_order [5];
    bit  seen;
`ifdef AUX_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{1, 2, 3, 0, 1};
`endif
    // rr_ptr is 1 after the single grant to source 0 in the reset test,
    // so the rotation continues from source 1.
    req_vld = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      run_until_launch(seen);
      checks++;
      if (!seen || arb_src !== SRC_W'(exp_order[n]) || arb_address !== exp_addr(exp_order[n])) begin
        errors++;
        $display("[TB] FAIL rr_grant_%0d got seen=%b src=%0d addr=%h expected src=%0d addr=%h",
                 n, seen, arb_src, arb_address, exp_order[n], exp_addr(exp_order[n]));
      end
      send_reply(2'b00, 1'b0, 1'b1);
      checks++;
      if (req_done !== (4'b0001 << exp_order[n])) begin
        errors++;
        $display("[TB] FAIL rr_done_%0d got %b expected %b", n, req_done, 4'b0001 << exp_order[n]);
      end
    end
    req_vld = 4'b0000;
    step();
    step();
  endtask

  task automatic test_retry_exhaustion();
    bit seen;
    int launches = 0;
    req_vld = 4'b0100;
    for (int n = 0; n <= MAX_RETRY; n++) begin
      run_until_launch(seen);
      req_vld = 4'b0000;
      if (seen) launches++;
      checks++;
      if (!seen || arb_retrans !== (n != 0) || arb_src !== 2'd2) begin
        errors++;
        $display("[TB] FAIL retry_launch_%0d got seen=%b retrans=%b src=%0d expected 1 %b 2",
                 n, seen, arb_retrans, arb_src, (n != 0));
      end
      send_reply(2'b10, 1'b0, 1'b1);
      checks++;
      if (n < MAX_RETRY && (req_failed !== 4'b0000 || req_done !== 4'b0000)) begin
        errors++;
        $display("[TB] FAIL retry_early_fail_%0d got failed=%b done=%b expected 0000", n, req_failed, req_done);
      end else if (n == MAX_RETRY && (req_failed !== 4'b0100 || req_done !== 4'b0000)) begin
        errors++;
        $display("[TB] FAIL retry_exhausted got failed=%b done=%b expected 0100 0000", req_failed, req_done);
      end
    end
    run_until_launch(seen);
    checks++;
    if (seen || launches != MAX_RETRY + 1 || arb_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL retry_count got launches=%0d extra=%b busy=%b expected %0d 0 0",
               launches, seen, arb_busy, MAX_RETRY + 1);
    end
  endtask

  task automatic test_timeout_vs_reply();
    bit seen;
    // Stray events while idle must not start or end anything.
    send_reply(2'b01, 1'b1, 1'b1);
    checks++;
    if (req_failed !== 4'b0000 || arb_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_events_ignored got failed=%b busy=%b expected 0000 0", req_failed, arb_busy);
    end
    req_vld = 4'b0010;
    run_until_launch(seen);
    req_vld = 4'b0000;
    send_reply(2'b00, 1'b1, 1'b1);
    checks++;
    if (!seen || req_done !== 4'b0010 || req_failed !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL tie_reply_wins got seen=%b done=%b failed=%b expected 1 0010 0000",
               seen, req_done, req_failed);
    end
    run_until_launch(seen);
    checks++;
    if (seen) begin
      errors++;
      $display("[TB] FAIL tie_no_retry got relaunch=%b expected 0", seen);
    end
    req_vld = 4'b0010;
    run_until_launch(seen);
    req_vld = 4'b0000;
    send_reply(2'b00, 1'b1, 1'b0);
    step();
    checks++;
    if (arb_tr_vld !== 1'b1 || arb_retrans !== 1'b1 || arb_src !== 2'd1) begin
      errors++;
      $display("[TB] FAIL timeout_relaunch got tr=%b retrans=%b src=%0d expected 1 1 1",
               arb_tr_vld, arb_retrans, arb_src);
    end
    send_reply(2'b00, 1'b0, 1'b1);
    checks++;
    if (req_done !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL timeout_then_ack got done=%b expected 0010", req_done);
    end
    step();
  endtask

  task automatic test_nack();
    bit seen;
    int first_src;
    int second_src;
`ifdef AUX_ARB_FIXED_PRIO_EN
    first_src  = 0;
    second_src = 0;
`else
    // Last grant went to source 1, so the pointer sits at 2: sources 3 then 0.
    first_src  = 3;
    second_src = 0;
`endif
    req_vld = 4'b1001;
    run_until_launch(seen);
    send_reply(2'b01, 1'b0, 1'b1);
    checks++;
    if (!seen || arb_src !== SRC_W'(first_src) || req_failed !== (4'b0001 << first_src)
        || req_done !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL nack_fail got seen=%b src=%0d failed=%b done=%b expected src=%0d failed=%b",
               seen, arb_src, req_failed, req_done, first_src, 4'b0001 << first_src);
    end
    run_until_launch(seen);
    req_vld = 4'b0000;
    checks++;
    if (!seen || arb_src !== SRC_W'(second_src) || arb_retrans !== 1'b0) begin
      errors++;
      $display("[TB] FAIL nack_next_grant got seen=%b src=%0d retrans=%b expected src=%0d retrans=0",
               seen, arb_src, arb_retrans, second_src);
    end
    send_reply(2'b11, 1'b0, 1'b1);
    checks++;
    if (req_failed !== (4'b0001 << second_src) || req_done !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL code11_as_nack got failed=%b done=%b expected %b 0000",
               req_failed, req_done, 4'b0001 << second_src);
    end
    step();
  endtask

  task automatic test_mid_op_reset();
    bit seen;
    req_vld = 4'b0100;
    run_until_launch(seen);
    step();
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (!seen || {arb_busy, arb_tr_vld, arb_src, arb_address, arb_data} !== '0) begin
      errors++;
      $display("[TB] FAIL async_reset got seen=%b busy=%b src=%0d addr=%h data=%h expected all 0",
               seen, arb_busy, arb_src, arb_address, arb_data);
    end
    send_reply(2'b00, 1'b0, 1'b1);
    checks++;
    if (req_done !== 4'b0000 || req_failed !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_no_pulse got done=%b failed=%b expected 0000 0000", req_done, req_failed);
    end
    rst_n = 1'b1;
    run_until_launch(seen);
    req_vld = 4'b0000;
    checks++;
    if (!seen || arb_src !== 2'd2 || arb_address !== exp_addr(2) || arb_retrans !== 1'b0) begin
      errors++;
      $display("[TB] FAIL regrant_after_reset got seen=%b src=%0d addr=%h expected 1 2 %h",
               seen, arb_src, arb_address, exp_addr(2));
    end
    send_reply(2'b00, 1'b0, 1'b1);
    checks++;
    if (req_done !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL regrant_done got %b expected 0100", req_done);
    end
    step();
  endtask

  initial begin
    rst_n         = 1'b0;
    req_vld       = '0;
    reply_ack     = 2'b00;
    reply_ack_vld = 1'b0;
    timer_timeout = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      req_cmd[2*i +: 2]            = 2'(i);
      req_addr[ADDR_W*i +: ADDR_W] = exp_addr(i);
      req_len[8*i +: 8]            = 8'(8'h10 + i);
      req_data[8*i +: 8]           = exp_data(i);
    end
    test_reset();
    test_round_robin();
    test_retry_exhaustion();
    test_timeout_vs_reply();
    test_nack();
    test_mid_op_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
